// File: rtl/apb_mem_slave.sv
// APB memory slave: a register-file memory behind a two-state APB FSM.
// Each transfer completes WAIT_CYCLES+1 cycles after its setup cycle.
// PSLVERR flags out-of-range words and an access phase that had no setup.
module apb_mem_slave #(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 8,
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic [ADDR_W-1:0] PADDR,
   input  logic              PWRITE,
   input  logic [DATA_W-1:0] PWDATA,
   output logic [DATA_W-1:0] PRDATA,
   output logic              PREADY,
   output logic              PSLVERR
);

   // Memory index width; one extra address bit keeps DEPTH == 2**ADDR_W comparable.
   localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [3:0]        WAIT_L  = 4'(WAIT_CYCLES);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_ACCESS = 1'b1
   } state_t;

   state_t            r_state;
   logic [3:0]        r_wcnt;
   logic [ADDR_W-1:0] r_addr;
   logic              r_write;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_range_err;
   logic              w_violation;
   logic              w_done;
   logic [IDX_W-1:0]  w_idx;

   // Wait counter decrement that holds at zero instead of wrapping.
   function automatic logic [3:0] f_dec_sat(input logic [3:0] v);
      return (v == 4'd0) ? 4'd0 : v - 4'd1;
   endfunction

   // Decode of the captured transfer and the live handshake.
   always_comb begin
      w_range_err = ({1'b0, r_addr} >= DEPTH_L);
      w_idx       = r_addr[IDX_W-1:0];
      // An access phase seen while idle never had a setup: answer at once with an error.
      w_violation = PRESETn && (r_state == S_IDLE) && PSEL && PENABLE;
      w_done      = (r_state == S_ACCESS) && PSEL && PENABLE && (r_wcnt == 4'd0);
   end

   // Response outputs; everything is zero outside the completion or violation cycle.
   always_comb begin
      PREADY  = w_done || w_violation;
      PSLVERR = w_violation || (w_done && w_range_err);
      PRDATA  = '0;
      if (w_done && !r_write && !w_range_err) begin
         PRDATA = r_mem[w_idx];
      end
   end

   // FSM, transfer capture, wait counting and memory write commit.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state <= S_IDLE;
         r_wcnt  <= 4'd0;
         r_addr  <= '0;
         r_write <= 1'b0;
         r_wdata <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (PSEL && !PENABLE) begin
                  r_addr  <= PADDR;
                  r_write <= PWRITE;
                  r_wdata <= PWDATA;
                  r_wcnt  <= WAIT_L;
                  r_state <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (!PSEL) begin
                  // Master abandoned the transfer: drop it without a write.
                  r_state <= S_IDLE;
               end else if (!PENABLE) begin
                  // A fresh setup replaces the pending one and restarts the wait.
                  r_addr  <= PADDR;
                  r_write <= PWRITE;
                  r_wdata <= PWDATA;
                  r_wcnt  <= WAIT_L;
               end else if (r_wcnt != 4'd0) begin
                  r_wcnt <= f_dec_sat(r_wcnt);
               end else begin
                  r_state <= S_IDLE;
                  if (r_write && !w_range_err) begin
                     r_mem[w_idx] <= r_wdata;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: a WAIT_CYCLES=2 instance driven by table vectors,
// hand-written corner sequences and a random phase against a reference memory,
// plus a WAIT_CYCLES=0 instance for the zero-wait case.
module tb_apb_mem_slave;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   // Instance A (two wait states)
   logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [7:0] paddr = 8'h00, pwdata = 8'h00;
   logic [7:0] prdata;
   logic       pready, pslverr;

   // Instance B (zero wait states)
   logic       b_psel = 1'b0, b_penable = 1'b0, b_pwrite = 1'b0;
   logic [7:0] b_paddr = 8'h00, b_pwdata = 8'h00;
   logic [7:0] b_prdata;
   logic       b_pready, b_pslverr;

   int n_checks = 0;
   int n_err    = 0;

   logic [7:0] ref_mem [64];

   typedef struct {
      logic [7:0] rd;
      logic       err;
      int         lat;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rd;
      logic       exp_err;
   } vec_t;

   always #5 clk = ~clk;

   apb_mem_slave #(.DATA_W(8), .ADDR_W(8), .DEPTH(64), .WAIT_CYCLES(2)) u_dut (
      .PCLK(clk), .PRESETn(rst_n), .PSEL(psel), .PENABLE(penable),
      .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata),
      .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
   );

   apb_mem_slave #(.DATA_W(8), .ADDR_W(8), .DEPTH(64), .WAIT_CYCLES(0)) u_dut0 (
      .PCLK(clk), .PRESETn(rst_n), .PSEL(b_psel), .PENABLE(b_penable),
      .PADDR(b_paddr), .PWRITE(b_pwrite), .PWDATA(b_pwdata),
      .PRDATA(b_prdata), .PREADY(b_pready), .PSLVERR(b_pslverr)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Wait (bounded) for PREADY on instance A; counts access cycles from the first.
   task automatic wait_ready(output int cyc, output bit got);
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (pready) got = 1'b1;
         else @(posedge clk) #1;
      end
      n_checks++;
      if (!got) begin
         n_err++;
         $display("FAIL ready_timeout: got no PREADY after %0d cycles expected PREADY", cyc);
      end
   endtask

   // One full transfer on instance A; expectation is queued at setup and checked at completion.
   task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                           input logic [7:0] exp_rd, input logic exp_err);
      exp_t e;
      int   cyc;
      bit   got;
      @(posedge clk) #1;
      psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wd;
      sb.push_back('{rd: exp_rd, err: exp_err, lat: 3});
      if (wr && addr < 8'd64) ref_mem[addr[5:0]] = wd;
      @(posedge clk) #1;
      penable = 1'b1;
      wait_ready(cyc, got);
      e = sb.pop_front();
      chk($sformatf("lat %s@%0h", wr ? "W" : "R", addr), cyc, e.lat);
      chk($sformatf("rdata %s@%0h", wr ? "W" : "R", addr), {24'd0, prdata}, {24'd0, e.rd});
      chk($sformatf("slverr %s@%0h", wr ? "W" : "R", addr), {31'd0, pslverr}, {31'd0, e.err});
   endtask

   task automatic model_xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wd);
      logic [7:0] er;
      er = (!wr && addr < 8'd64) ? ref_mem[addr[5:0]] : 8'h00;
      apb_xfer(wr, addr, wd, er, addr >= 8'd64);
   endtask

   task automatic bus_idle();
      @(posedge clk) #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   initial begin
      vec_t vecs[12];
      int   cyc;
      bit   got;

      vecs[0]  = '{1'b1, 8'h10, 8'hA5, 8'h00, 1'b0};
      vecs[1]  = '{1'b0, 8'h10, 8'h00, 8'hA5, 1'b0};
      vecs[2]  = '{1'b1, 8'h00, 8'h5E, 8'h00, 1'b0};
      vecs[3]  = '{1'b1, 8'h40, 8'h3C, 8'h00, 1'b1};
      vecs[4]  = '{1'b0, 8'h40, 8'h00, 8'h00, 1'b1};
      vecs[5]  = '{1'b0, 8'h00, 8'h00, 8'h5E, 1'b0};
      vecs[6]  = '{1'b1, 8'hFF, 8'h01, 8'h00, 1'b1};
      vecs[7]  = '{1'b0, 8'h3F, 8'h00, 8'h00, 1'b0};
      vecs[8]  = '{1'b1, 8'h3F, 8'hC3, 8'h00, 1'b0};
      vecs[9]  = '{1'b0, 8'h3F, 8'h00, 8'hC3, 1'b0};
      vecs[10] = '{1'b0, 8'h80, 8'h00, 8'h00, 1'b1};
      vecs[11] = '{1'b0, 8'h00, 8'h00, 8'h5E, 1'b0};

      for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;

      // Reset state
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("reset pready", {31'd0, pready}, 32'd0);
      chk("reset pslverr", {31'd0, pslverr}, 32'd0);
      chk("reset prdata", {24'd0, prdata}, 32'd0);
      chk("reset b_pready", {31'd0, b_pready}, 32'd0);

      // Every word reads zero after reset, three-cycle latency
      for (int a = 0; a < 64; a++) apb_xfer(1'b0, 8'(a), 8'h00, 8'h00, 1'b0);

      // Table vectors, back to back
      for (int i = 0; i < 12; i++) begin
         apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_err);
      end
      bus_idle();

      // Access phase without setup
      @(posedge clk) #1;
      psel = 1'b1; penable = 1'b1; paddr = 8'h05; pwrite = 1'b1; pwdata = 8'hEE;
      @(negedge clk);
      chk("viol pready", {31'd0, pready}, 32'd1);
      chk("viol pslverr", {31'd0, pslverr}, 32'd1);
      @(posedge clk) #1;
      psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      chk("post viol pready", {31'd0, pready}, 32'd0);
      apb_xfer(1'b0, 8'h05, 8'h00, 8'h00, 1'b0);
      apb_xfer(1'b1, 8'h05, 8'h77, 8'h00, 1'b0);
      apb_xfer(1'b0, 8'h05, 8'h00, 8'h77, 1'b0);

      // Abort in the second wait cycle
      apb_xfer(1'b1, 8'h02, 8'h55, 8'h00, 1'b0);
      @(posedge clk) #1;
      psel = 1'b1; penable = 1'b0; paddr = 8'h02; pwrite = 1'b1; pwdata = 8'h99;
      @(posedge clk) #1;
      penable = 1'b1;
      @(negedge clk);
      chk("abort wait1 pready", {31'd0, pready}, 32'd0);
      @(posedge clk) #1;
      psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      chk("abort wait2 pready", {31'd0, pready}, 32'd0);
      repeat (3) begin
         @(negedge clk);
         chk("abort later pready", {31'd0, pready}, 32'd0);
      end
      apb_xfer(1'b0, 8'h02, 8'h00, 8'h55, 1'b0);

      // Repeated setup replaces the first one
      @(posedge clk) #1;
      psel = 1'b1; penable = 1'b0; paddr = 8'h07; pwrite = 1'b1; pwdata = 8'h11;
      @(posedge clk) #1;
      paddr = 8'h08; pwdata = 8'h22;
      @(posedge clk) #1;
      penable = 1'b1; paddr = 8'h09; pwdata = 8'hDD;
      wait_ready(cyc, got);
      chk("resetup lat", cyc, 32'd3);
      chk("resetup pslverr", {31'd0, pslverr}, 32'd0);
      ref_mem[8] = 8'h22;
      apb_xfer(1'b0, 8'h07, 8'h00, 8'h00, 1'b0);
      apb_xfer(1'b0, 8'h08, 8'h00, 8'h22, 1'b0);
      apb_xfer(1'b0, 8'h09, 8'h00, 8'h00, 1'b0);

      // Random transfers against the reference memory, including out-of-range words
      for (int i = 0; i < 40; i++) begin
         model_xfer(1'($urandom_range(0, 1)), 8'($urandom_range(0, 79)), 8'($urandom));
      end

      // Reset during a completing read
      apb_xfer(1'b1, 8'h21, 8'h5A, 8'h00, 1'b0);
      @(posedge clk) #1;
      psel = 1'b1; penable = 1'b0; paddr = 8'h21; pwrite = 1'b0;
      @(posedge clk) #1;
      penable = 1'b1;
      wait_ready(cyc, got);
      chk("pre-reset prdata", {24'd0, prdata}, 32'h5A);
      #1 rst_n = 1'b0;
      #1;
      chk("mid-reset pready", {31'd0, pready}, 32'd0);
      chk("mid-reset pslverr", {31'd0, pslverr}, 32'd0);
      chk("mid-reset prdata", {24'd0, prdata}, 32'd0);
      psel = 1'b0; penable = 1'b0;
      @(posedge clk) #1;
      rst_n = 1'b1;
      for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
      apb_xfer(1'b0, 8'h21, 8'h00, 8'h00, 1'b0);
      apb_xfer(1'b0, 8'h10, 8'h00, 8'h00, 1'b0);
      apb_xfer(1'b0, 8'h05, 8'h00, 8'h00, 1'b0);
      bus_idle();

      // Zero-wait instance: address change during access is ignored
      @(posedge clk) #1;
      b_psel = 1'b1; b_penable = 1'b0; b_paddr = 8'h3F; b_pwrite = 1'b1; b_pwdata = 8'h11;
      @(posedge clk) #1;
      b_penable = 1'b1; b_paddr = 8'h00; b_pwdata = 8'hEE;
      @(negedge clk);
      chk("w0 write pready", {31'd0, b_pready}, 32'd1);
      chk("w0 write pslverr", {31'd0, b_pslverr}, 32'd0);
      @(posedge clk) #1;
      b_penable = 1'b0; b_paddr = 8'h3F; b_pwrite = 1'b0;
      @(negedge clk);
      chk("w0 setup pready", {31'd0, b_pready}, 32'd0);
      @(posedge clk) #1;
      b_penable = 1'b1;
      @(negedge clk);
      chk("w0 rd3F pready", {31'd0, b_pready}, 32'd1);
      chk("w0 rd3F prdata", {24'd0, b_prdata}, 32'h11);
      @(posedge clk) #1;
      b_penable = 1'b0; b_paddr = 8'h00;
      @(posedge clk) #1;
      b_penable = 1'b1;
      @(negedge clk);
      chk("w0 rd00 pready", {31'd0, b_pready}, 32'd1);
      chk("w0 rd00 prdata", {24'd0, b_prdata}, 32'h00);
      @(posedge clk) #1;
      b_psel = 1'b0; b_penable = 1'b0;
      @(negedge clk);
      chk("w0 idle pready", {31'd0, b_pready}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/apb_mem_slave.md
Name: apb_mem_slave

Overview:
- APB slave that sits directly downstream of the APB master bridge. One instance hangs off each of the bridge's two selects.
- Decodes an 8-bit word address into an internal register-file memory.
- Inserts a programmable number of wait states.
- Returns PRDATA, PREADY and PSLVERR to the bridge.
- Flags out-of-range addresses and protocol violations through PSLVERR.

Parameters:
- DATA_W, 8: data bus width (PWDATA/PRDATA).
- ADDR_W, 8: slave-local address width; the bridge's PADDR[7:0] connects here.
- DEPTH, 64: number of memory words; valid addresses are 0..DEPTH-1, with DEPTH <= 2**ADDR_W.
- WAIT_CYCLES, 2: wait states inserted in the access phase, range 0..15.

Ports:
- PCLK, input, 1: APB clock; all state changes on rising edge.
- PRESETn, input, 1: asynchronous active-low reset.
- PSEL, input, 1: slave select from bridge (PSEL1 or PSEL2).
- PENABLE, input, 1: access-phase indicator.
- PADDR, input, ADDR_W: word address.
- PWRITE, input, 1: 1 = write, 0 = read.
- PWDATA, input, DATA_W: write data.
- PRDATA, output, DATA_W: read data; valid only while PREADY=1 and the transfer is a read.
- PREADY, output, 1: transfer-complete strobe.
- PSLVERR, output, 1: error response; valid only while PREADY=1.

Behaviour:
- Reset (PRESETn=0, asynchronous):
  - State returns to IDLE.
  - Wait counter, captured address/data/write registers and every memory word clear to 0.
  - PREADY=0, PSLVERR=0, PRDATA=0.
  - Reset asserted mid-transfer aborts the transfer with no memory update.
- State machine, two states:
  - IDLE:
    - PSEL=1 and PENABLE=0 (setup phase): capture PADDR, PWRITE, PWDATA; load wcnt=WAIT_CYCLES; go to ACCESS.
    - PSEL=1 and PENABLE=1 (access with no setup): protocol violation. Drive PREADY=1 and PSLVERR=1 combinationally in the same cycle, with no memory effect; stay in IDLE.
  - ACCESS:
    - PSEL=1, PENABLE=1, wcnt!=0: PREADY=0 and wcnt decrements.
    - PSEL=1, PENABLE=1, wcnt==0: PREADY=1 (combinational from registered state/wcnt and the live PSEL/PENABLE). Go to IDLE at the next edge.
    - PSEL=0: abort. Go to IDLE, no write, PREADY stays 0.
    - PSEL=1, PENABLE=0 (repeated setup): recapture inputs, reload wcnt, stay in ACCESS.
- Latency: the transfer completes WAIT_CYCLES+1 cycles after the setup cycle. With WAIT_CYCLES=0, PREADY is high in the first access cycle.
- Captured values:
  - Address, direction and write data are those captured in the setup cycle.
  - Changes on PADDR/PWDATA/PWRITE during ACCESS are ignored.
- Error decode: range_err = (captured address >= DEPTH).
  - At completion: PSLVERR = range_err.
  - Out-of-range write is discarded.
  - Out-of-range read returns PRDATA=0.
- Write commit: mem[addr] <= wdata on the PCLK edge where PREADY=1, write=1, range_err=0. Exactly one write per transfer.
- Read data:
  - PRDATA = mem[addr] while PREADY=1, write=0, range_err=0; otherwise PRDATA=0.
  - A read of a location written by the immediately preceding transfer returns the new value.
- Outputs outside completion: PREADY and PSLVERR are 0 in every cycle except the completion cycle (or the IDLE violation cycle).
- Back-to-back transfers: the bridge returns to SETUP after ENABLE. The slave is in IDLE that cycle and accepts the new setup with no dead cycle.
- Width rules:
  - wcnt is 4 bits and saturates at 0, never wrapping.
  - Address comparison is unsigned on the full ADDR_W bits.

Test Plan:
- Reset then read all addresses 0..63 with WAIT_CYCLES=2 -> each read completes on the 3rd cycle after setup with PRDATA=0x00, PSLVERR=0; PREADY low in the two wait cycles.
- Write 0xA5 to addr 0x10, then immediately read 0x10 back-to-back -> write commits at its PREADY edge; read returns 0xA5, PSLVERR=0; no idle cycle needed between transfers.
- Write 0x3C to addr 0x40 (>= DEPTH), then read 0x40 -> both complete with PREADY=1, PSLVERR=1; read PRDATA=0x00; no word in memory changes.
- Drive PSEL=1, PENABLE=1 without a setup cycle -> same-cycle PREADY=1, PSLVERR=1; memory untouched; a following normal write/read of 0x05=0x77 completes cleanly.
- Start write of 0x99 to 0x02, drop PSEL in the second wait cycle -> no PREADY, mem[0x02] unchanged. Also: assert PRESETn=0 mid-ACCESS on another transfer -> outputs 0 immediately, memory cleared.
- Rebuild with WAIT_CYCLES=0; write 0x11 to 0x3F, change PADDR to 0x00 during the access phase -> PREADY in the first access cycle; mem[0x3F]=0x11; mem[0x00] unchanged.
